// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares the serial 7-segment shift chain (SEGCLK/SEGCLR/SEGDT/SEGEN) between
//   the score source (port 0) and the auxiliary source (port 1). A round-robin
//   arbiter picks one frame, latches it and shifts it out MSB first.
//   Optional build macro: SEG_ARB_REFRESH_EN -- after REFRESH_CYCLES idle cycles
//   the last latched frame is resent without an ack.

module seg_display_arbiter #(
    parameter int FRAME_W = 64,
    parameter int CLK_DIV = 2
`ifdef SEG_ARB_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 1 << 20
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [FRAME_W-1:0] frame0,
    output logic               ack0,
    input  logic               req1,
    input  logic [FRAME_W-1:0] frame1,
    output logic               ack1,
    output logic               busy,
    output logic               SEGCLK,
    output logic               SEGCLR,
    output logic               SEGDT,
    output logic               SEGEN
);

    localparam int BIT_W = $clog2(FRAME_W);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               grant_q, grant_d;           // port being served
    logic               last_grant_q, last_grant_d; // port served last (tie breaker)
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               segclk_q, segclk_d;
    logic               busy_q, busy_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               chain_on_q;
    logic [FRAME_W-1:0] frame_sel;

`ifdef SEG_ARB_REFRESH_EN
    localparam int IDLE_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES - 1);

    logic               refresh_q, refresh_d;       // current send is a refresh
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [FRAME_W-1:0] last_frame_q, last_frame_d;
`endif

    // SEGDT is the MSB of the shift register: after FRAME_W shifts it is all
    // zeros, so the line idles low without a separate data flop.
    assign SEGDT  = shreg_q[FRAME_W-1];
    assign SEGCLK = segclk_q;
    assign SEGCLR = chain_on_q;
    assign SEGEN  = chain_on_q;
    assign busy   = busy_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;

    // Next-state logic: arbitration, frame latch and the bit/phase sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        segclk_d     = segclk_q;
        busy_d       = busy_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        frame_sel    = grant_q ? frame1 : frame0;
`ifdef SEG_ARB_REFRESH_EN
        refresh_d    = refresh_q;
        idle_cnt_d   = idle_cnt_q;
        last_frame_d = last_frame_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_GRANT;
                    // On a tie the port that was not served last time wins.
                    grant_d = (req0 && req1) ? ~last_grant_q : req1;
`ifdef SEG_ARB_REFRESH_EN
                    refresh_d  = 1'b0;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = S_GRANT;
                    refresh_d  = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
`endif
                end
            end

            S_GRANT: begin
                state_d   = S_SHIFT;
                busy_d    = 1'b1;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                segclk_d  = 1'b0;
`ifdef SEG_ARB_REFRESH_EN
                if (refresh_q) begin
                    shreg_d = last_frame_q;
                end else begin
                    shreg_d      = frame_sel;
                    last_frame_d = frame_sel;
                    last_grant_d = grant_q;
                    ack0_d       = ~grant_q;
                    ack1_d       = grant_q;
                end
`else
                shreg_d      = frame_sel;
                last_grant_d = grant_q;
                ack0_d       = ~grant_q;
                ack1_d       = grant_q;
`endif
            end

            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!segclk_q) begin
                        segclk_d = 1'b1;
                    end else begin
                        // End of the high phase: drop the clock and present
                        // the next bit together, so data moves only while low.
                        segclk_d = 1'b0;
                        shreg_d  = {shreg_q[FRAME_W-2:0], 1'b0};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                segclk_d = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Core registers; reset aborts any frame and clears the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            // NOTE: the shift register is reset because SEGDT is taken
            // straight from its MSB and must read 0 during reset.
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            segclk_q     <= 1'b0;
            busy_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            chain_on_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            segclk_q     <= segclk_d;
            busy_q       <= busy_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            chain_on_q   <= 1'b1;
        end
    end

`ifdef SEG_ARB_REFRESH_EN
    // Refresh bookkeeping: idle timer and copy of the last real frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q    <= 1'b0;
            idle_cnt_q   <= '0;
            last_frame_q <= '0;
        end else begin
            refresh_q    <= refresh_d;
            idle_cnt_q   <= idle_cnt_d;
            last_frame_q <= last_frame_d;
        end
    end
`endif

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter
//   Scoreboard bench: expected serial bits are queued when a frame request is
//   driven and popped on every SEGCLK rising edge. Scenario tasks check acks,
//   latency, busy length, arbitration order and reset behaviour.
//   Build with SEG_ARB_REFRESH_EN defined to include the refresh scenario.

module tb_seg_display_arbiter;

    localparam int FRAME_W = 64;
    localparam int CLK_DIV = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0 = 1'b0;
    logic               req1 = 1'b0;
    logic [FRAME_W-1:0] frame0 = '0;
    logic [FRAME_W-1:0] frame1 = '0;
    logic               ack0, ack1, busy, SEGCLK, SEGCLR, SEGDT, SEGEN;

    int   n_checks = 0;
    int   n_fail = 0;
    int   rise_count = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .FRAME_W(FRAME_W),
        .CLK_DIV(CLK_DIV)
`ifdef SEG_ARB_REFRESH_EN
        ,
        .REFRESH_CYCLES(100)
`endif
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .frame0(frame0),
        .ack0  (ack0),
        .req1  (req1),
        .frame1(frame1),
        .ack1  (ack1),
        .busy  (busy),
        .SEGCLK(SEGCLK),
        .SEGCLR(SEGCLR),
        .SEGDT (SEGDT),
        .SEGEN (SEGEN)
    );

    // Step to just after the falling edge: outputs stable, inputs safe to drive.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [FRAME_W-1:0] f);
        for (int i = FRAME_W - 1; i >= 0; i--) exp_q.push_back(f[i]);
    endtask

    // Scoreboard: pop one expected bit per SEGCLK rising edge; SEGDT may only
    // change while SEGCLK is low.
    task automatic monitor();
        logic clk_prev;
        logic dt_prev;
        logic exp_bit;
        clk_prev = 1'b0;
        dt_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (SEGCLK === 1'b1 && clk_prev === 1'b0) begin
                rise_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL segclk_rise: edge %0d with SEGDT=%b, required no edge", rise_count, SEGDT);
                end else begin
                    exp_bit = exp_q.pop_front();
                    if (SEGDT !== exp_bit) begin
                        n_fail++;
                        $display("FAIL segdt_bit: edge %0d got %b, required %b", rise_count, SEGDT, exp_bit);
                    end
                end
            end
            if (SEGDT !== dt_prev) begin
                n_checks++;
                if (SEGCLK !== 1'b0) begin
                    n_fail++;
                    $display("FAIL segdt_stable: SEGDT changed with SEGCLK=%b, required 0", SEGCLK);
                end
            end
            clk_prev = SEGCLK;
            dt_prev  = SEGDT;
        end
    endtask

    task automatic wait_ack(input int port, input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((port == 0 && ack0 === 1'b1) || (port == 1 && ack1 === 1'b1)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_first_ack(input int max, output int cycles, output int port);
        cycles = -1;
        port   = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                cycles = i;
                port   = (ack0 === 1'b1 && ack1 === 1'b1) ? 2 : (ack1 === 1'b1 ? 1 : 0);
                break;
            end
        end
    endtask

    // Wait for busy to reach a level; also report whether any ack pulsed.
    task automatic wait_busy(input logic level, input int max, output int cycles, output bit saw_ack);
        cycles  = -1;
        saw_ack = 1'b0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (ack0 === 1'b1 || ack1 === 1'b1) saw_ack = 1'b1;
            if (busy === level) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int r0;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, ack0, ack1, SEGCLK, SEGDT, SEGCLR, SEGEN} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {busy, ack0, ack1, SEGCLK, SEGDT, SEGCLR, SEGEN});
        end
        rst = 1'b0;
        n_checks++;
        if (SEGCLR !== 1'b0) begin
            n_fail++;
            $display("FAIL segclr_before_clock: got %b, required 0", SEGCLR);
        end
        tick();
        n_checks++;
        if ({SEGCLR, SEGEN} !== 2'b11) begin
            n_fail++;
            $display("FAIL chain_enable: SEGCLR,SEGEN got %b, required 11", {SEGCLR, SEGEN});
        end
        r0 = rise_count;
        repeat (20) tick();
        n_checks++;
        if (rise_count != r0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: edges %0d busy %b, required 0 edges busy 0", rise_count - r0, busy);
        end
    endtask

    task automatic test_single_frame();
        logic [FRAME_W-1:0] f;
        int r0, cyc;
        bit saw;
        f = 64'h8000_0000_0000_0001;
        push_frame(f);
        frame0 = f;
        req0   = 1'b1;
        r0     = rise_count;
        tick();
        n_checks++;
        if (ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ack0_early: got %b one cycle after req, required 0", ack0);
        end
        tick();
        n_checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ack0_latency: ack0=%b ack1=%b two cycles after req, required 1 0", ack0, ack1);
        end
        req0 = 1'b0;
        wait_busy(1'b0, 400, cyc, saw);
        n_checks++;
        if (cyc != 257) begin
            n_fail++;
            $display("FAIL busy_length: got %0d cycles, required 257", cyc);
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL ack0_pulse: ack seen after the first cycle, required single pulse");
        end
        n_checks++;
        if (rise_count - r0 != 64 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL edge_count: got %0d edges %0d bits left, required 64 edges 0 left",
                     rise_count - r0, exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int cyc, port;
        bit saw;
        do_reset();
        push_frame(64'hA5A5_0F0F_3C3C_FF00);
        push_frame(64'h1357_9BDF_2468_ACE0);
        frame0 = 64'hA5A5_0F0F_3C3C_FF00;
        frame1 = 64'h1357_9BDF_2468_ACE0;
        req0   = 1'b1;
        req1   = 1'b1;
        wait_first_ack(10, cyc, port);
        n_checks++;
        if (port != 0 || cyc != 2) begin
            n_fail++;
            $display("FAIL tie_first: port %0d after %0d cycles, required port 0 after 2", port, cyc);
        end
        req0 = 1'b0;
        wait_ack(1, 400, cyc);
        n_checks++;
        if (cyc != 259) begin
            n_fail++;
            $display("FAIL tie_second_gap: ack1 %0d cycles after ack0, required 259", cyc);
        end
        req1 = 1'b0;
        push_frame(64'hDEAD_BEEF_0000_FFFF);
        push_frame(64'h0F1E_2D3C_4B5A_6978);
        frame0 = 64'hDEAD_BEEF_0000_FFFF;
        frame1 = 64'h0F1E_2D3C_4B5A_6978;
        req0   = 1'b1;
        req1   = 1'b1;
        wait_first_ack(400, cyc, port);
        n_checks++;
        if (port != 0 || cyc != 259) begin
            n_fail++;
            $display("FAIL rr_port0: port %0d after %0d cycles, required port 0 after 259", port, cyc);
        end
        req0 = 1'b0;
        wait_ack(1, 400, cyc);
        n_checks++;
        if (cyc != 259) begin
            n_fail++;
            $display("FAIL rr_port1: ack1 %0d cycles after ack0, required 259", cyc);
        end
        req1 = 1'b0;
        wait_busy(1'b0, 400, cyc, saw);
        n_checks++;
        if (cyc != 257) begin
            n_fail++;
            $display("FAIL rr_drain: busy fell after %0d cycles, required 257", cyc);
        end
    endtask

    task automatic test_midframe_request();
        int cyc;
        bit saw;
        push_frame(64'h0123_4567_89AB_CDEF);
        frame0 = 64'h0123_4567_89AB_CDEF;
        req0   = 1'b1;
        wait_ack(0, 10, cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL mid_ack0: got %0d cycles, required 2", cyc);
        end
        req0   = 1'b0;
        frame0 = 64'hFEDC_BA98_7654_3210;   // must not disturb the frame in flight
        repeat (50) tick();
        push_frame(64'h3C3C_C3C3_5A5A_A5A5);
        frame1 = 64'h3C3C_C3C3_5A5A_A5A5;
        req1   = 1'b1;
        wait_busy(1'b0, 400, cyc, saw);
        n_checks++;
        if (saw || cyc < 0) begin
            n_fail++;
            $display("FAIL mid_no_ack1: ack seen=%0d busy wait=%0d, required no ack and busy falling", saw, cyc);
        end
        wait_ack(1, 10, cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL mid_ack1_after_done: got %0d cycles after busy fell, required 2", cyc);
        end
        req1   = 1'b0;
        frame1 = '0;
        wait_busy(1'b0, 400, cyc, saw);
        n_checks++;
        if (cyc != 257) begin
            n_fail++;
            $display("FAIL mid_frame1_length: got %0d cycles, required 257", cyc);
        end
    endtask

    task automatic test_reset_midframe();
        int r0, cyc;
        bit saw;
        push_frame('1);
        frame0 = '1;
        req0   = 1'b1;
        r0     = rise_count;
        wait_ack(0, 10, cyc);
        req0 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rise_count - r0 >= 30) break;
            tick();
        end
        n_checks++;
        if (rise_count - r0 != 30) begin
            n_fail++;
            $display("FAIL reach_30_edges: got %0d edges, required 30", rise_count - r0);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, ack0, ack1, SEGCLK, SEGDT, SEGCLR, SEGEN} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, required 0000000",
                     {busy, ack0, ack1, SEGCLK, SEGDT, SEGCLR, SEGEN});
        end
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        push_frame(64'hF00D_0000_1234_8001);
        frame0 = 64'hF00D_0000_1234_8001;
        req0   = 1'b1;
        r0     = rise_count;
        wait_ack(0, 10, cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL post_reset_ack0: got %0d cycles, required 2", cyc);
        end
        req0 = 1'b0;
        wait_busy(1'b0, 400, cyc, saw);
        n_checks++;
        if (cyc != 257 || rise_count - r0 != 64) begin
            n_fail++;
            $display("FAIL post_reset_frame: busy %0d edges %0d, required 257 and 64", cyc, rise_count - r0);
        end
    endtask

`ifdef SEG_ARB_REFRESH_EN
    task automatic test_refresh();
        int cyc;
        bit saw;
        push_frame(64'hF00D_0000_1234_8001);   // last latched frame is resent
        wait_busy(1'b1, 200, cyc, saw);
        n_checks++;
        if (cyc != 101) begin
            n_fail++;
            $display("FAIL refresh_gap: busy rose after %0d idle cycles, required 101", cyc);
        end
        n_checks++;
        if (saw || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_no_ack: ack0=%b ack1=%b seen=%0d, required no ack", ack0, ack1, saw);
        end
        repeat (10) tick();
        push_frame(64'h7777_0000_AAAA_5555);
        frame0 = 64'h7777_0000_AAAA_5555;
        req0   = 1'b1;
        wait_busy(1'b0, 400, cyc, saw);
        n_checks++;
        if (saw || cyc < 0) begin
            n_fail++;
            $display("FAIL refresh_req_wait: ack seen=%0d busy wait=%0d, required no ack and busy falling", saw, cyc);
        end
        wait_ack(0, 10, cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL refresh_ack0_after_done: got %0d cycles, required 2", cyc);
        end
        req0 = 1'b0;
        wait_busy(1'b0, 400, cyc, saw);
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_round_robin();
        test_midframe_request();
        test_reset_midframe();
`ifdef SEG_ARB_REFRESH_EN
        test_refresh();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: %0d bits never shifted, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
